// File: rtl/mod_mul_unit.sv
// rtl/mod_mul_unit.sv - sequential (a*b) mod p, MSB-first interleaved shift-add
// One multiplier bit per clock; start/finish pulse handshake shared with the other arithmetic units.
module mod_mul_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic             mul_start_i,
  output logic             mul_busy_o,
  output logic             mul_finish_o,
  output logic [WIDTH-1:0] mul_result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, r_q, result_q;
  logic             finish_q;

  logic             p_small;
  logic [WIDTH:0]   p_ext, t1_raw, t2_raw;
  logic [WIDTH-1:0] t1, t2, a_sel;

  assign p_small = (p_i[WIDTH-1:1] == '0);
  assign p_ext   = {1'b0, p_q};

  // When a reduction happens the true difference is < 2^WIDTH, so a WIDTH-bit subtract is exact.
  assign t1_raw = {r_q, 1'b0};
  assign t1     = (t1_raw >= p_ext) ? (t1_raw[WIDTH-1:0] - p_q) : t1_raw[WIDTH-1:0];
  assign a_sel  = b_q[cnt_q] ? a_q : '0;
  assign t2_raw = {1'b0, t1} + {1'b0, a_sel};
  assign t2     = (t2_raw >= p_ext) ? (t2_raw[WIDTH-1:0] - p_q) : t2_raw[WIDTH-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mul_start_i && !p_small) state_d = RUN;
      RUN:  if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_busy_o   = (state_q == RUN);
    mul_finish_o = finish_q;
    mul_result_o = result_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start_i) begin
            if (p_small) begin
              // Modulus 0 or 1: every residue is 0, answer immediately without running.
              result_q <= '0;
              finish_q <= 1'b1;
            end else begin
              a_q   <= a_i;
              b_q   <= b_i;
              p_q   <= p_i;
              r_q   <= '0;
              cnt_q <= CNT_MAX;
            end
          end
        end
        RUN: begin
          r_q <= t2;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            result_q <= t2;
            finish_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
